i2s_tx_scheduler: RTL and testbench



---
 rtl/i2s_types.sv | 18 +
 rtl/i2s_sample_slot.sv | 43 ++++
 rtl/i2s_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_i2s_tx_scheduler.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/i2s_types.sv
// i2s_types: shared scheduler state, channel encoding and default widths
package i2s_types;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LEFT  = 2'd1,
      S_RIGHT = 2'd2
   } state_e;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } chan_e;

   localparam int BITS_DEF  = 8;
   localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/i2s_sample_slot.sv
// i2s_sample_slot: one-entry sample buffer, loaded by valid/ready and emptied by a drain strobe
module i2s_sample_slot
   import i2s_types::*;
#(
   parameter int BITS = BITS_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_i,
   output logic            ready_o,
   input  logic [BITS-1:0] data_i,
   input  logic            drain_i,
   output logic            full_o,
   output logic [BITS-1:0] data_o
);

   logic            full_q, full_d;
   logic [BITS-1:0] buf_q, buf_d;
   logic            load;

   assign ready_o = ~full_q;
   assign load    = valid_i & ~full_q;
   assign full_o  = full_q;
   assign data_o  = buf_q;

   // a load only happens while empty, so it can never meet a drain
   always_comb begin
      full_d = load ? 1'b1 : (drain_i ? 1'b0 : full_q);
      buf_d  = load ? data_i : buf_q;
   end

   // slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q <= 1'b0;
         buf_q  <= '0;
      end else begin
         full_q <= full_d;
         buf_q  <= buf_d;
      end
   end

endmodule

// File: rtl/i2s_tx_scheduler.sv
// i2s_tx_scheduler: L/R word scheduler feeding the I2S serializer; I2S_UNDERRUN_REPEAT_EN repeats the last real sample on underrun
module i2s_tx_scheduler
   import i2s_types::*;
#(
   parameter int BITS  = BITS_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_enable,
   input  logic             l_valid,
   output logic             l_ready,
   input  logic [BITS-1:0]  l_data,
   input  logic             r_valid,
   output logic             r_ready,
   input  logic [BITS-1:0]  r_data,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [BITS-1:0]  o_data,
   output logic             o_ws,
   output logic             o_busy,
   output logic [CNT_W-1:0] underrun_count,
   output logic [CNT_W-1:0] frame_count
);

   state_e           state_q, state_d;
   logic             o_valid_q, o_valid_d;
   logic [BITS-1:0]  o_data_q, o_data_d;
   logic             o_ws_q, o_ws_d;
   logic [CNT_W-1:0] under_q, under_d, under_inc;
   logic [CNT_W-1:0] frame_q, frame_d;
   logic             l_full, r_full, l_drain, r_drain, free;
   logic [BITS-1:0]  l_buf, r_buf, l_fill, r_fill;

   i2s_sample_slot #(.BITS(BITS)) u_left (
      .clk(clk), .rst(rst), .valid_i(l_valid), .ready_o(l_ready), .data_i(l_data),
      .drain_i(l_drain), .full_o(l_full), .data_o(l_buf)
   );

   i2s_sample_slot #(.BITS(BITS)) u_right (
      .clk(clk), .rst(rst), .valid_i(r_valid), .ready_o(r_ready), .data_i(r_data),
      .drain_i(r_drain), .full_o(r_full), .data_o(r_buf)
   );

`ifdef I2S_UNDERRUN_REPEAT_EN
   logic [BITS-1:0] last_l_q, last_r_q;

   // remember the most recent real word per channel for repeat-on-underrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_l_q <= '0;
         last_r_q <= '0;
      end else begin
         if (l_drain) last_l_q <= l_buf;
         if (r_drain) last_r_q <= r_buf;
      end
   end

   assign l_fill = last_l_q;
   assign r_fill = last_r_q;
`else
   assign l_fill = '0;
   assign r_fill = '0;
`endif

   assign free           = ~o_valid_q | o_ready;
   assign under_inc      = under_q + {{(CNT_W-1){1'b0}}, ~&under_q};
   assign o_valid        = o_valid_q;
   assign o_data         = o_data_q;
   assign o_ws           = o_ws_q;
   assign o_busy         = state_q != S_IDLE;
   assign underrun_count = under_q;
   assign frame_count    = frame_q;

   // next state and output word: a word is issued only when the output register is free
   always_comb begin
      state_d   = state_q;
      o_valid_d = o_valid_q;
      o_data_d  = o_data_q;
      o_ws_d    = o_ws_q;
      under_d   = under_q;
      frame_d   = frame_q;
      l_drain   = 1'b0;
      r_drain   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (free) o_valid_d = 1'b0;
            if (i_enable) state_d = S_LEFT;
         end
         S_LEFT: if (free) begin
            o_valid_d = 1'b1;
            o_ws_d    = LEFT;
            o_data_d  = l_full ? l_buf : l_fill;
            l_drain   = l_full;
            under_d   = l_full ? under_q : under_inc;
            state_d   = S_RIGHT;
         end
         S_RIGHT: if (free) begin
            o_valid_d = 1'b1;
            o_ws_d    = RIGHT;
            o_data_d  = r_full ? r_buf : r_fill;
            r_drain   = r_full;
            under_d   = r_full ? under_q : under_inc;
            frame_d   = frame_q + 1'b1;
            state_d   = i_enable ? S_LEFT : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // scheduler registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         o_valid_q <= 1'b0;
         o_data_q  <= '0;
         o_ws_q    <= 1'b0;
         under_q   <= '0;
         frame_q   <= '0;
      end else begin
         state_q   <= state_d;
         o_valid_q <= o_valid_d;
         o_data_q  <= o_data_d;
         o_ws_q    <= o_ws_d;
         under_q   <= under_d;
         frame_q   <= frame_d;
      end
   end

endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// tb_i2s_tx_scheduler: directed checks of the scheduler in its default (zero-fill) build
module tb_i2s_tx_scheduler;

   logic       clk = 1'b0;
   logic       rst, i_enable, l_valid, r_valid, o_ready;
   logic [7:0] l_data, r_data;
   logic       l_ready, r_ready, o_valid, o_ws, o_busy;
   logic [7:0] o_data, underrun_count, frame_count;
   int         checks = 0;
   int         errors = 0;

   i2s_tx_scheduler #(.BITS(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .i_enable(i_enable),
      .l_valid(l_valid), .l_ready(l_ready), .l_data(l_data),
      .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data),
      .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_ws(o_ws),
      .o_busy(o_busy), .underrun_count(underrun_count), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [7:0] d, input logic ws);
      chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
      chk({tag, "_data"}, {24'd0, o_data}, {24'd0, d});
      chk({tag, "_ws"}, {31'd0, o_ws}, {31'd0, ws});
   endtask

   initial begin
      rst = 1'b1; i_enable = 1'b0; l_valid = 1'b0; r_valid = 1'b0; o_ready = 1'b0;
      l_data = 8'h00; r_data = 8'h00;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_l_ready", {31'd0, l_ready}, 32'd1);
      chk("rst_r_ready", {31'd0, r_ready}, 32'd1);
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_o_data", {24'd0, o_data}, 32'd0);
      chk("rst_under", {24'd0, underrun_count}, 32'd0);
      chk("rst_frame", {24'd0, frame_count}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);

      // normal frame, with enable dropped right after the left word
      l_valid = 1'b1; l_data = 8'hA5; r_valid = 1'b1; r_data = 8'h3C;
      tick();
      l_valid = 1'b0; r_valid = 1'b0;
      chk("pre_l_ready", {31'd0, l_ready}, 32'd0);
      chk("pre_r_ready", {31'd0, r_ready}, 32'd0);
      i_enable = 1'b1; o_ready = 1'b1;
      tick();
      chk("en_busy", {31'd0, o_busy}, 32'd1);
      chk("en_no_valid", {31'd0, o_valid}, 32'd0);
      tick();
      chk_word("norm_l", 8'hA5, 1'b0);
      chk("norm_l_ready", {31'd0, l_ready}, 32'd1);
      i_enable = 1'b0;
      tick();
      chk_word("norm_r", 8'h3C, 1'b1);
      chk("norm_frame", {24'd0, frame_count}, 32'd1);
      chk("norm_under", {24'd0, underrun_count}, 32'd0);
      chk("norm_idle", {31'd0, o_busy}, 32'd0);
      tick();
      chk("norm_drain", {31'd0, o_valid}, 32'd0);

      // two frames of underrun fills
      i_enable = 1'b1;
      tick();
      for (int k = 0; k < 4; k++) begin
         if (k == 3) i_enable = 1'b0;
         tick();
         chk_word("und_word", 8'h00, k[0]);
      end
      chk("und_count", {24'd0, underrun_count}, 32'd4);
      chk("und_frame", {24'd0, frame_count}, 32'd3);
      chk("und_idle", {31'd0, o_busy}, 32'd0);
      tick();
      chk("und_drain", {31'd0, o_valid}, 32'd0);

      // backpressure on a pending left word while the left slot refills
      o_ready = 1'b0;
      l_valid = 1'b1; l_data = 8'h5A;
      tick();
      l_valid = 1'b0; i_enable = 1'b1;
      tick();
      tick();
      chk_word("bp_l", 8'h5A, 1'b0);
      chk("bp_l_ready_free", {31'd0, l_ready}, 32'd1);
      l_valid = 1'b1; l_data = 8'h77;
      tick();
      l_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk_word("bp_hold", 8'h5A, 1'b0);
         chk("bp_l_ready", {31'd0, l_ready}, 32'd0);
      end
      i_enable = 1'b0; o_ready = 1'b1;
      tick();
      chk_word("bp_r_fill", 8'h00, 1'b1);
      chk("bp_under", {24'd0, underrun_count}, 32'd5);
      chk("bp_frame", {24'd0, frame_count}, 32'd4);
      tick();
      chk("bp_idle_valid", {31'd0, o_valid}, 32'd0);
      chk("bp_still_full", {31'd0, l_ready}, 32'd0);
      i_enable = 1'b1;
      tick();
      tick();
      chk_word("bp_l2", 8'h77, 1'b0);
      chk("bp_l2_ready", {31'd0, l_ready}, 32'd1);
      i_enable = 1'b0;
      tick();
      chk_word("bp_r2_fill", 8'h00, 1'b1);
      chk("bp2_under", {24'd0, underrun_count}, 32'd6);
      chk("bp2_frame", {24'd0, frame_count}, 32'd5);
      tick();
      chk("bp2_drain", {31'd0, o_valid}, 32'd0);

      // saturation: 300 more fill words
      i_enable = 1'b1;
      tick();
      for (int k = 0; k < 300; k++) tick();
      chk("sat_under", {24'd0, underrun_count}, 32'd255);
      chk("sat_frame", {24'd0, frame_count}, 32'd155);
      chk_word("sat_last", 8'h00, 1'b1);

      // mid-frame asynchronous reset
      tick();
      chk_word("mid_l", 8'h00, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("ar_o_valid", {31'd0, o_valid}, 32'd0);
      chk("ar_o_ws", {31'd0, o_ws}, 32'd0);
      chk("ar_o_data", {24'd0, o_data}, 32'd0);
      chk("ar_busy", {31'd0, o_busy}, 32'd0);
      chk("ar_under", {24'd0, underrun_count}, 32'd0);
      chk("ar_frame", {24'd0, frame_count}, 32'd0);
      chk("ar_l_ready", {31'd0, l_ready}, 32'd1);
      chk("ar_r_ready", {31'd0, r_ready}, 32'd1);
      i_enable = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      chk("post_rst_valid", {31'd0, o_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
